// File: rtl/flags_stack_reg.sv
// Condition-flag register with per-bit masked writes and a LIFO save/restore
// stack for nested interrupt/call entry, with sticky misuse error bits.
module flags_stack_reg #(
  parameter  int unsigned WIDTH = 3,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic [WIDTH-1:0] d,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err,
  output logic             prot_err
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    depth_next;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;
  logic             ovf_next;
  logic             unf_next;
  logic             prot_next;

  // Status decodes depend only on registered depth and stack contents.
  assign full   = (depth == CW'(DEPTH));
  assign empty  = (depth == '0);
  assign wr_idx = IW'(depth);
  assign rd_idx = IW'(depth - CW'(1));
  assign top    = empty ? '0 : stack[rd_idx];

  // Next-state: a legal pop overrides the masked write; conflicting requests are dropped.
  always_comb begin
    q_next     = q;
    depth_next = depth;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ovf_next   = ovf_err & ~err_clr;
    unf_next   = unf_err & ~err_clr;
    prot_next  = prot_err & ~err_clr;

    if (en) begin
      q_next = (q & ~wr_mask) | (d & wr_mask);
    end

    if (push && pop) begin
      prot_next = 1'b1;
    end else if (push) begin
      if (full) begin
        ovf_next = 1'b1;
      end else begin
        do_push    = 1'b1;
        depth_next = depth + CW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf_next = 1'b1;
      end else begin
        do_pop     = 1'b1;
        depth_next = depth - CW'(1);
        q_next     = stack[rd_idx];
      end
    end
  end

  // State registers; the saved entry is the flag value before this cycle's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= '0;
      depth    <= '0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
      prot_err <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      q        <= q_next;
      depth    <= depth_next;
      ovf_err  <= ovf_next;
      unf_err  <= unf_next;
      prot_err <= prot_next;
      if (do_push) begin
        stack[wr_idx] <= q;
      end
    end
  end

endmodule

// File: tb/tb_flags_stack_reg.sv
// Scoreboard bench for flags_stack_reg: stimulus queues expected state,
// independent monitor processes pop and compare after each update.
module tb_flags_stack_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] wr_mask = '0;
  logic [2:0] d = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] q;
  logic [2:0] top;
  logic [2:0] depth;
  logic       full;
  logic       empty;
  logic       ovf_err;
  logic       unf_err;
  logic       prot_err;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [2:0] q;
    logic [2:0] depth;
    logic [2:0] top;
    logic [2:0] err;   // {ovf, unf, prot}
    string      name;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;

  flags_stack_reg #(.WIDTH(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_mask(wr_mask), .d(d),
    .push(push), .pop(pop), .err_clr(err_clr),
    .q(q), .top(top), .depth(depth), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err), .prot_err(prot_err)
  );

  always #5 clk = ~clk;

  task automatic check_one();
    exp_t e;
    logic ef;
    logic ee;
    e  = exp_q.pop_front();
    ef = (e.depth == 3'd4);
    ee = (e.depth == 3'd0);
    compared++;
    if (q !== e.q || depth !== e.depth || top !== e.top || full !== ef ||
        empty !== ee || {ovf_err, unf_err, prot_err} !== e.err) begin
      mismatched++;
      $display("FAIL %s: got q=%b depth=%0d top=%b full=%b empty=%b err=%b, want q=%b depth=%0d top=%b full=%b empty=%b err=%b",
               e.name, q, depth, top, full, empty, {ovf_err, unf_err, prot_err},
               e.q, e.depth, e.top, ef, ee, e.err);
    end
  endtask

  // Monitor for clocked updates.
  initial forever begin
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) check_one();
  end

  // Monitor for asynchronous (reset) updates between edges.
  initial forever begin
    @(chk_ev);
    #2;
    if (exp_q.size() > 0) check_one();
  end

  task automatic expect_state(input logic [2:0] eq, input logic [2:0] ed,
                              input logic [2:0] et, input logic [2:0] eerr,
                              input string nm);
    exp_t e;
    e.q = eq; e.depth = ed; e.top = et; e.err = eerr; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic e, input logic [2:0] m, input logic [2:0] dv,
                      input logic pu, input logic po, input logic ec,
                      input logic [2:0] eq, input logic [2:0] ed,
                      input logic [2:0] et, input logic [2:0] eerr,
                      input string nm);
    @(negedge clk);
    en = e; wr_mask = m; d = dv; push = pu; pop = po; err_clr = ec;
    expect_state(eq, ed, et, eerr, nm);
  endtask

  task automatic idle();
    en = 1'b0; wr_mask = '0; d = '0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    // Reset state while rst is held.
    @(negedge clk);
    #1;
    expect_state(3'b000, 3'd0, 3'b000, 3'b000, "reset");
    -> chk_ev;
    @(negedge clk);
    rst = 1'b0;

    //    en   mask    d       pu   po   ec    q       dep   top     err
    step(1'b1, 3'b111, 3'b101, 1'b0, 1'b0, 1'b0, 3'b101, 3'd0, 3'b000, 3'b000, "wr_all");
    step(1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 3'b111, 3'd0, 3'b000, 3'b000, "wr_mask");
    step(1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b111, 3'd0, 3'b000, 3'b000, "wr_hold");
    step(1'b1, 3'b111, 3'b101, 1'b0, 1'b0, 1'b0, 3'b101, 3'd0, 3'b000, 3'b000, "rt_setup");
    step(1'b1, 3'b111, 3'b010, 1'b1, 1'b0, 1'b0, 3'b010, 3'd1, 3'b101, 3'b000, "rt_push_wr");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b101, 3'd0, 3'b000, 3'b000, "rt_pop");
    // Fill and overflow.
    step(1'b1, 3'b111, 3'b001, 1'b0, 1'b0, 1'b0, 3'b001, 3'd0, 3'b000, 3'b000, "fill_q1");
    step(1'b1, 3'b111, 3'b010, 1'b1, 1'b0, 1'b0, 3'b010, 3'd1, 3'b001, 3'b000, "fill_p1");
    step(1'b1, 3'b111, 3'b011, 1'b1, 1'b0, 1'b0, 3'b011, 3'd2, 3'b010, 3'b000, "fill_p2");
    step(1'b1, 3'b111, 3'b100, 1'b1, 1'b0, 1'b0, 3'b100, 3'd3, 3'b011, 3'b000, "fill_p3");
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b100, 3'd4, 3'b100, 3'b000, "fill_p4");
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b100, 3'd4, 3'b100, 3'b100, "ovf_push");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b100, 3'd3, 3'b011, 3'b100, "drain_1");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b011, 3'd2, 3'b010, 3'b100, "drain_2");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b010, 3'd1, 3'b001, 3'b100, "drain_3");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b001, 3'd0, 3'b000, 3'b100, "drain_4");
    // Underflow, protocol and clear.
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b001, 3'd0, 3'b000, 3'b110, "unf_pop");
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b001, 3'd1, 3'b001, 3'b110, "prot_p1");
    step(1'b1, 3'b111, 3'b110, 1'b1, 1'b0, 1'b0, 3'b110, 3'd2, 3'b001, 3'b110, "prot_p2");
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 3'b110, 3'd2, 3'b001, 3'b111, "prot_both");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b110, 3'd2, 3'b001, 3'b000, "err_clr");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b001, 3'd1, 3'b001, 3'b000, "clr_pop1");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b001, 3'd0, 3'b000, 3'b000, "clr_pop2");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'b001, 3'd0, 3'b000, 3'b010, "clr_set_wins");
    // Pop priority over en.
    step(1'b1, 3'b111, 3'b110, 1'b0, 1'b0, 1'b0, 3'b110, 3'd0, 3'b000, 3'b010, "pri_wr");
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b110, 3'd1, 3'b110, 3'b010, "pri_push");
    step(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'd1, 3'b110, 3'b010, "pri_clobber");
    step(1'b1, 3'b111, 3'b001, 1'b0, 1'b1, 1'b0, 3'b110, 3'd0, 3'b000, 3'b010, "pri_pop");
    step(1'b1, 3'b001, 3'b001, 1'b0, 1'b1, 1'b0, 3'b111, 3'd0, 3'b000, 3'b010, "unf_en_wr");
    // Build depth 3 with ovf set, then async reset.
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111, 3'd0, 3'b000, 3'b000, "ar_clr");
    step(1'b1, 3'b111, 3'b011, 1'b1, 1'b0, 1'b0, 3'b011, 3'd1, 3'b111, 3'b000, "ar_p1");
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b011, 3'd2, 3'b011, 3'b000, "ar_p2");
    step(1'b1, 3'b111, 3'b101, 1'b1, 1'b0, 1'b0, 3'b101, 3'd3, 3'b011, 3'b000, "ar_p3");
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b101, 3'd4, 3'b101, 3'b000, "ar_p4");
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b101, 3'd4, 3'b101, 3'b100, "ar_ovf");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b101, 3'd3, 3'b011, 3'b100, "ar_pop");
    @(negedge clk);
    idle();
    #1;
    rst = 1'b1;
    expect_state(3'b000, 3'd0, 3'b000, 3'b000, "async_reset");
    -> chk_ev;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 3'd1, 3'b000, 3'b000, "post_rst_push");
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'd0, 3'b000, 3'b000, "post_rst_pop");

    @(negedge clk);
    idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/flags_stack_reg.md
# flags_stack_reg

Parametrised condition-flag register with per-bit write mask and a LIFO save/restore stack for nested interrupt and call entry. Sits beside the ALU in the execute stage. It holds the live flags (default Z, V, N), pushes them on exception/call entry and restores them on return. Overflow and underflow of the stack are reported through sticky error bits, never silently corrupted state.

## Interface
- WIDTH, 3, number of flag bits; bit 2 = Z (zero), bit 1 = V (overflow), bit 0 = N (sign) in the default configuration
- DEPTH, 4, stack entries; legal range 1..16
- CW, $clog2(DEPTH+1), derived width of depth count (localparam)

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  flag write enable
- wr_mask  in  WIDTH  per-bit write select, qualified by en
- d  in  WIDTH  new flag values from ALU
- push  in  1  save current flags onto stack
- pop  in  1  restore flags from top of stack
- err_clr  in  1  synchronous clear of all sticky error bits
- q  out  WIDTH  live flags (registered)
- top  out  WIDTH  peek of top stack entry; 0 when empty
- depth  out  CW  number of valid stack entries (registered)
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- ovf_err  out  1  sticky: push attempted while full
- unf_err  out  1  sticky: pop attempted while empty
- prot_err  out  1  sticky: push and pop asserted in same cycle

## Operation
- Reset (async, any time, including mid-push/pop): q = 0, depth = 0, all stack entries = 0, all error bits = 0; full = 0, empty = 1, top = 0.
- Masked write: when en, q_next[i] = wr_mask[i] ? d[i] : q[i]; unmasked bits hold. en with wr_mask = 0 leaves q unchanged.
- Push (push=1, pop=0, not full): stack[depth] <= current q (pre-update value), depth <= depth+1. en in the same cycle still applies its masked write to q.
- Push while full: stack and depth unchanged; ovf_err <= 1; en write to q still applies.
- Pop (pop=1, push=0, not empty): q <= stack[depth-1] in full, all WIDTH bits; depth <= depth-1. Pop has priority over en; d and wr_mask are ignored that cycle. The vacated entry retains stale data and is not observable through top.
- Pop while empty: depth unchanged; unf_err <= 1; en write to q applies normally.
- push and pop together: both ignored, depth and stack unchanged; prot_err <= 1; en write to q applies normally.
- err_clr: clears ovf_err, unf_err and prot_err. If a new error occurs in the same cycle, set wins.
- full, empty and top are combinational decodes of registered depth and stack only; there is no combinational path from any input to any output.

## Timing
- Every update takes effect at the rising clk edge after inputs are sampled; q, depth and the error bits are visible one cycle after the request.
- Back-to-back push/pop on consecutive cycles is supported at full rate with no bubble.
- Push then immediate pop restores the value of q as it was before the push, even if en modified q in the push cycle.
- Reset deassertion: the first edge with rst low performs normal operation; there is no extra idle cycle.

## Test plan
- Masked write: reset, en=1 wr_mask=3'b111 d=3'b101 -> q=101; then en=1 wr_mask=3'b010 d=3'b010 -> q=111; en=0 d=000 -> q stays 111.
- Push/pop round trip: q=101, push with en=1 mask=111 d=010 -> next cycle q=010, depth=1, top=101; pop -> q=101, depth=0, empty=1.
- Fill and overflow (DEPTH=4): four pushes of q=001,010,011,100 -> full=1, depth=4, top=100; fifth push -> depth stays 4, ovf_err=1; four pops return 100,011,010,001 in that order.
- Underflow and protocol: pop when empty -> unf_err=1, q unchanged; push+pop together at depth=2 -> depth stays 2, prot_err=1; err_clr -> all errors 0 next cycle; err_clr with simultaneous empty pop -> unf_err stays 1.
- Pop priority: depth=1 with top=110, pop with en=1 mask=111 d=001 -> q=110, not 001.
- Async reset mid-operation: at depth=3 with ovf_err=1, assert rst between edges -> q, depth, top and errors read 0 and empty=1 immediately, without waiting for a clk edge; first post-reset push stores 000.
